// File: rtl/fcb_pkg.sv
// Shared types and width helpers for the frame capture buffer.
package fcb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        WAIT_SOF,
        CAPTURE,
        READOUT
    } fcb_state_e;

    // Sideband carried alongside a pixel while its RAM read is in flight.
    typedef struct packed {
        logic pad;
        logic eol;
        logic last;
    } fcb_tag_t;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int fcb_cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to address n entries.
    function automatic int fcb_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fcb_if.sv
// Pixel source input and readout stream of the frame capture buffer.
interface fcb_if #(
    parameter int PIX_W = 8
);
    logic             fval;
    logic             lval;
    logic             dval;
    logic [PIX_W-1:0] pix_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [PIX_W-1:0] rd_data;
    logic             rd_eol;
    logic             rd_last;

    modport master (
        output fval, lval, dval, pix_data, rd_ready,
        input  rd_valid, rd_data, rd_eol, rd_last
    );

    modport slave (
        input  fval, lval, dval, pix_data, rd_ready,
        output rd_valid, rd_data, rd_eol, rd_last
    );
endinterface

// File: rtl/fcb_pix_ram.sv
// Simple dual-port pixel store; the read register holds its value while re=0.
module fcb_pix_ram #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/frame_capture_buffer.sv
// Captures one complete frame after arm, then streams it row-major over
// valid/ready, zero-padding lines shorter than the first counted line.
module frame_capture_buffer
    import fcb_pkg::*;
#(
    parameter  int PIX_W      = 8,
    parameter  int MAX_WIDTH  = 640,
    parameter  int MAX_HEIGHT = 480,
    localparam int WW         = fcb_cnt_w(MAX_WIDTH),
    localparam int HW         = fcb_cnt_w(MAX_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    fcb_if.slave          bus,
    input  logic          arm,
    output logic          busy,
    output logic          done,
    output logic [WW-1:0] frame_width,
    output logic [HW-1:0] frame_height,
    output logic          err_overflow,
    output logic          err_line_len
);
    localparam int DEPTH = MAX_WIDTH * MAX_HEIGHT;
    localparam int AW    = fcb_addr_w(DEPTH);
    localparam int LAW   = fcb_addr_w(MAX_HEIGHT);
    localparam logic [WW-1:0] MAXW = WW'(MAX_WIDTH);
    localparam logic [HW-1:0] MAXH = HW'(MAX_HEIGHT);

    fcb_state_e state, nstate;

    logic [WW-1:0]    x, rcol, row_len, len_val;
    logic [HW-1:0]    y, rrow, y_inc, y_end;
    logic             lval_q, cap, sample, we, eol_in, line_cnt, frame_end;
    logic             advance, issue, issued_all, final_hs, row_eol;
    logic [1:0]       vld_pipe;
    fcb_tag_t         s1_tag, tag_n;
    logic [PIX_W-1:0] ram_q, rd_data_q;
    logic             rd_eol_q, rd_last_q;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [WW-1:0]    len_mem [0:MAX_HEIGHT-1];

    // The fval edge that leaves WAIT_SOF is already part of the frame.
    assign cap       = (state == CAPTURE) || (state == WAIT_SOF && bus.fval);
    assign sample    = cap && bus.fval && bus.lval && bus.dval;
    assign we        = sample && (x < MAXW) && (y < MAXH);
    assign eol_in    = (state == CAPTURE) && lval_q && (!bus.lval || !bus.fval);
    assign line_cnt  = eol_in && (x != '0);
    assign frame_end = (state == CAPTURE) && !bus.fval;
    assign y_inc     = (y < MAXH) ? y + HW'(1) : y;
    assign y_end     = line_cnt ? y_inc : y;
    assign len_val   = (frame_width == '0 || x < frame_width) ? x : frame_width;

    assign wr_addr = AW'(32'(y) * MAX_WIDTH + 32'(x));
    assign rd_addr = AW'(32'(rrow) * MAX_WIDTH + 32'(rcol));
    assign row_len = len_mem[LAW'(rrow)];
    assign row_eol = (rcol == frame_width - WW'(1));
    assign tag_n   = '{pad:  (rcol >= row_len),
                       eol:  row_eol,
                       last: row_eol && (rrow == frame_height - HW'(1))};

    // Stage 0 issues the RAM read, stage 1 is the RAM register, then rd_* regs.
    assign advance  = !vld_pipe[1] || bus.rd_ready;
    assign issue    = (state == READOUT) && !issued_all && advance;
    assign final_hs = (state == READOUT) && vld_pipe[1] && bus.rd_ready && rd_last_q;

    assign busy         = (state != IDLE);
    assign bus.rd_valid = vld_pipe[1];
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_eol   = rd_eol_q;
    assign bus.rd_last  = rd_last_q;

    fcb_pix_ram #(.PIX_W(PIX_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_addr),
        .wdata (bus.pix_data),
        .re    (issue),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:     if (arm) nstate = SYNC;
            SYNC:     if (!bus.fval) nstate = WAIT_SOF;
            WAIT_SOF: if (bus.fval) nstate = CAPTURE;
            CAPTURE:  if (frame_end) nstate = (y_end == '0) ? IDLE : READOUT;
            READOUT:  if (final_hs) nstate = IDLE;
            default:  nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (line_cnt && y < MAXH) len_mem[LAW'(y)] <= len_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done         <= 1'b0;
            frame_width  <= '0;
            frame_height <= '0;
            err_overflow <= 1'b0;
            err_line_len <= 1'b0;
            x            <= '0;
            y            <= '0;
            lval_q       <= 1'b0;
            rcol         <= '0;
            rrow         <= '0;
            issued_all   <= 1'b0;
            vld_pipe     <= '0;
            s1_tag       <= '0;
            rd_data_q    <= '0;
            rd_eol_q     <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            done   <= 1'b0;
            lval_q <= bus.lval;

            if (state == IDLE && arm) begin
                err_overflow <= 1'b0;
                err_line_len <= 1'b0;
                frame_width  <= '0;
                frame_height <= '0;
            end
            if (state == SYNC) begin
                x <= '0;
                y <= '0;
            end

            if (cap) begin
                if (sample) begin
                    if (!(x < MAXW && y < MAXH)) err_overflow <= 1'b1;
                    if (x < MAXW) x <= x + WW'(1);
                end
                if (line_cnt) begin
                    x <= '0;
                    y <= y_inc;
                    if (frame_width == '0)     frame_width  <= x;
                    else if (x != frame_width) err_line_len <= 1'b1;
                end
                if (frame_end) begin
                    frame_height <= y_end;
                    if (y_end == '0) done <= 1'b1;
                end
            end

            if (state == READOUT) begin
                if (issue) begin
                    s1_tag <= tag_n;
                    if (tag_n.last) issued_all <= 1'b1;
                    else if (tag_n.eol) begin
                        rcol <= '0;
                        rrow <= rrow + HW'(1);
                    end else begin
                        rcol <= rcol + WW'(1);
                    end
                end
                if (advance) begin
                    vld_pipe  <= {vld_pipe[0], issue};
                    rd_data_q <= s1_tag.pad ? '0 : ram_q;
                    rd_eol_q  <= vld_pipe[0] && s1_tag.eol;
                    rd_last_q <= vld_pipe[0] && s1_tag.last;
                end
                if (final_hs) done <= 1'b1;
            end else begin
                rcol       <= '0;
                rrow       <= '0;
                issued_all <= 1'b0;
                vld_pipe   <= '0;
                rd_eol_q   <= 1'b0;
                rd_last_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_frame_capture_buffer.sv
// Directed bench for frame_capture_buffer with a 4x4 store.
module tb_frame_capture_buffer;
    localparam int PIX_W = 8;
    localparam int MW    = 4;
    localparam int MH    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arm = 1'b0;
    logic       busy, done, err_overflow, err_line_len;
    logic [2:0] frame_width, frame_height;

    int checks   = 0;
    int failures = 0;
    int pc       = 0;
    int exp_d[$];

    fcb_if #(.PIX_W(PIX_W)) bus ();

    frame_capture_buffer #(.PIX_W(PIX_W), .MAX_WIDTH(MW), .MAX_HEIGHT(MH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .arm          (arm),
        .busy         (busy),
        .done         (done),
        .frame_width  (frame_width),
        .frame_height (frame_height),
        .err_overflow (err_overflow),
        .err_line_len (err_line_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_it();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("busy_after_arm", busy, 1);
        tick();
    endtask

    task automatic send_line(input int n);
        bus.lval = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.dval     = 1'b1;
            bus.pix_data = 8'(pc);
            pc++;
            tick();
        end
        bus.dval = 1'b0;
        bus.lval = 1'b0;
        tick();
    endtask

    // Line 1 has length lb, all others la.
    task automatic send_frame(input int nl, input int la, input int lb);
        bus.fval = 1'b1;
        tick();
        for (int l = 0; l < nl; l++) send_line((l == 1) ? lb : la);
        bus.fval = 1'b0;
        tick();
    endtask

    task automatic collect(input int n, input int tot, input int w,
                           input bit stall, input bit chk_done);
        int got_n = 0;
        int cyc = 0;
        int lat = -1;
        int last_cyc = 0;
        bit stalled = 0;
        logic [PIX_W-1:0] hold_d = '0;
        while (got_n < n && cyc < 400) begin
            bus.rd_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (stalled) begin
                chk("stall_valid", bus.rd_valid, 1);
                chk("stall_data", bus.rd_data, hold_d);
            end
            stalled = 0;
            if (bus.rd_valid) begin
                if (lat < 0) lat = cyc;
                if (bus.rd_ready) begin
                    chk("data", bus.rd_data, exp_d[got_n]);
                    chk("eol", bus.rd_eol, (got_n % w) == w - 1);
                    chk("last", bus.rd_last, got_n == tot - 1);
                    got_n++;
                    last_cyc = cyc;
                end else begin
                    stalled = 1;
                    hold_d  = bus.rd_data;
                end
            end
            tick();
            cyc++;
        end
        bus.rd_ready = 1'b0;
        chk("beats", got_n, n);
        chk("first_latency_le2", (lat >= 0 && lat <= 2), 1);
        if (!stall) chk("throughput", last_cyc - lat, n - 1);
        if (chk_done) begin
            chk("done_pulse", done, 1);
            chk("busy_end", busy, 0);
            chk("valid_end", bus.rd_valid, 0);
            tick();
            chk("done_once", done, 0);
        end
    endtask

    task automatic chk_status(input int w, input int h, input int ovf, input int ll);
        chk("frame_width", frame_width, w);
        chk("frame_height", frame_height, h);
        chk("err_overflow", err_overflow, ovf);
        chk("err_line_len", err_line_len, ll);
    endtask

    initial begin
        bus.fval = 1'b0; bus.lval = 1'b0; bus.dval = 1'b0;
        bus.pix_data = '0; bus.rd_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", bus.rd_valid, 0);
        chk("rst_eol", bus.rd_eol, 0);
        chk("rst_last", bus.rd_last, 0);
        chk_status(0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // Basic 4x3 frame
        exp_d = {};
        for (int i = 0; i < 12; i++) exp_d.push_back(i);
        arm_it();
        pc = 0;
        send_frame(3, 4, 4);
        collect(12, 12, 4, 0, 1);
        chk_status(4, 3, 0, 0);

        // Arm mid-frame: that frame is skipped
        bus.fval = 1'b1;
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        pc = 100;
        send_line(4);
        bus.fval = 1'b0;
        tick();
        tick();
        chk("sync_busy", busy, 1);
        exp_d = {};
        for (int i = 0; i < 8; i++) exp_d.push_back(i);
        pc = 0;
        send_frame(2, 4, 4);
        collect(8, 8, 4, 0, 1);
        chk_status(4, 2, 0, 0);

        // 6-pixel lines into a 4-wide store
        exp_d = {};
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 4; i++) exp_d.push_back(l * 6 + i);
        arm_it();
        pc = 0;
        send_frame(2, 6, 6);
        collect(8, 8, 4, 0, 1);
        chk_status(4, 2, 1, 0);

        // Line lengths 4,2,4: short line zero-padded
        exp_d = {0, 1, 2, 3, 4, 5, 0, 0, 6, 7, 8, 9};
        arm_it();
        pc = 0;
        send_frame(3, 4, 2);
        collect(12, 12, 4, 0, 1);
        chk_status(4, 3, 0, 1);

        // Backpressure pattern 1,0,0,1
        exp_d = {};
        for (int i = 0; i < 12; i++) exp_d.push_back(i);
        arm_it();
        pc = 0;
        send_frame(3, 4, 4);
        collect(12, 12, 4, 1, 1);
        chk_status(4, 3, 0, 0);

        // Five lines into a 4-line store: height saturates
        exp_d = {};
        for (int i = 0; i < 16; i++) exp_d.push_back(i);
        arm_it();
        pc = 0;
        send_frame(5, 4, 4);
        collect(16, 16, 4, 0, 1);
        chk_status(4, 4, 1, 0);

        // Empty frame: straight back to idle with done
        arm_it();
        bus.fval = 1'b1;
        tick();
        tick();
        bus.fval = 1'b0;
        tick();
        chk("empty_done", done, 1);
        chk("empty_busy", busy, 0);
        chk("empty_height", frame_height, 0);
        tick();
        chk("empty_done_once", done, 0);

        // Reset mid-readout
        exp_d = {};
        for (int i = 0; i < 12; i++) exp_d.push_back(i);
        arm_it();
        pc = 0;
        send_frame(3, 4, 4);
        collect(3, 12, 4, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", bus.rd_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_width", frame_width, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_done", done, 0);
        end
        arm_it();
        pc = 0;
        send_frame(3, 4, 4);
        collect(12, 12, 4, 0, 1);
        chk_status(4, 3, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_capture_buffer.md
FRAME_CAPTURE_BUFFER -- requirements
Module: frame_capture_buffer

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning pixel data width in bits.
REQ-002 SHALL have parameter MAX_WIDTH, default 640, meaning maximum stored pixels per line.
REQ-003 SHALL have parameter MAX_HEIGHT, default 480, meaning maximum stored lines per frame.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports fval, lval, dval  in  1 each  frame, line and data valid from the pixel source.
REQ-007 SHALL have port pix_data  in  PIX_W  pixel sample, qualified by fval&lval&dval.
REQ-008 SHALL have port arm  in  1  single-cycle request to capture the next complete frame.
REQ-009 SHALL have ports rd_valid out 1, rd_ready in 1, rd_data out PIX_W  readout stream with valid/ready handshake.
REQ-010 SHALL have ports rd_eol out 1 and rd_last out 1, marking the last pixel of a line and the last pixel of the frame.
REQ-011 SHALL have ports busy out 1 and done out 1; done is a one-cycle pulse.
REQ-012 SHALL have ports frame_width out WW and frame_height out HW, with WW=$clog2(MAX_WIDTH+1) and HW=$clog2(MAX_HEIGHT+1).
REQ-013 SHALL have ports err_overflow out 1 and err_line_len out 1, both sticky.

Function
REQ-014 SHALL implement FSM states IDLE, SYNC, WAIT_SOF, CAPTURE and READOUT.
REQ-015 IDLE: arm=1 SHALL go to SYNC, clear both error flags, and zero frame_width and frame_height; arm in any other state SHALL be ignored.
REQ-016 SYNC: the FSM SHALL wait for fval=0 and then go to WAIT_SOF, so that a partially elapsed frame is never captured.
REQ-017 WAIT_SOF: fval=1 SHALL go to CAPTURE, with the x and y counters at 0.
REQ-018 CAPTURE: each cycle with fval&lval&dval SHALL write pix_data at (y,x) when x<MAX_WIDTH and y<MAX_HEIGHT, then increment x.
REQ-019 A sample with x>=MAX_WIDTH or y>=MAX_HEIGHT SHALL be dropped and SHALL set err_overflow.
REQ-020 End of line: lval falling (or fval falling while lval=1) with x>0 SHALL store line length min(x,MAX_WIDTH), increment y and reset x to 0.
REQ-021 A line that ends with x=0 SHALL NOT be counted.
REQ-022 The first counted line SHALL set frame_width.
REQ-023 Any later counted line whose length differs from frame_width SHALL set err_line_len; stored lines SHALL keep their own length only up to frame_width, and shorter lines SHALL be padded in readout with value 0.
REQ-024 fval falling SHALL set frame_height=min(y,MAX_HEIGHT) and go to READOUT; if frame_height=0 it SHALL instead go to IDLE with done pulsed.
REQ-025 READOUT SHALL stream frame_height x frame_width pixels in row-major order.
REQ-026 Readout memory read latency SHALL be hidden internally; rd_data SHALL be registered.
REQ-027 rd_valid, once high, SHALL hold, together with rd_data, rd_eol and rd_last, stable until rd_ready=1.
REQ-028 Sustained rd_ready=1 SHALL give one pixel per cycle after a first-pixel latency of no more than 2 cycles.
REQ-029 rd_eol SHALL be set when column=frame_width-1; rd_last SHALL be set on the final pixel.
REQ-030 The handshake of the final pixel SHALL pulse done on the next cycle and return the FSM to IDLE.
REQ-031 Input activity (fval, lval, dval) during READOUT SHALL be ignored.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 Counter arithmetic SHALL saturate at MAX_WIDTH and MAX_HEIGHT and SHALL never wrap.

Reset
REQ-034 rst SHALL force state IDLE and set busy, done, rd_valid, rd_eol, rd_last, err_overflow, err_line_len, frame_width, frame_height and all counters to 0.
REQ-035 rst SHALL leave memory contents unspecified.
REQ-036 rst mid-capture or mid-readout SHALL abort the operation with no done pulse.

Structure
REQ-037 Package fcb_pkg SHALL hold the FSM state enum and a width helper function for the counter widths.
REQ-038 Pixel storage SHALL be a sub-module fcb_pix_ram: simple dual-port, MAX_WIDTH*MAX_HEIGHT x PIX_W, 1-cycle registered read.
REQ-039 A per-line length RAM (MAX_HEIGHT x WW) SHALL sit inside frame_capture_buffer.

Verification
REQ-040 Arm, then a 4x3 frame of pixels 0..11 with rd_ready=1 -> 12 beats of 0..11, rd_eol on 3/7/11, rd_last on 11, done pulse, width=4, height=3, no errors.
REQ-041 Arm while fval=1 mid-frame -> the current frame is skipped and the next frame is captured in full.
REQ-042 MAX_WIDTH=4 with a 6-pixel line -> err_overflow=1, frame_width=4, and the readout holds only the first 4 pixels of each line.
REQ-043 A 3-line frame with lengths 4,2,4 -> err_line_len=1, readout line 1 = p0,p1,0,0.
REQ-044 rd_ready toggled in the pattern 1,0,0,1 -> no beat lost or duplicated, and rd_data stable during stall cycles.
REQ-045 rst asserted mid-READOUT -> rd_valid=0 and busy=0 immediately, no done pulse; a following arm captures normally.
